// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
package sipo_deserializer_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Width of a bit-position counter able to index 0..width-1.
  function automatic int unsigned pos_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input and parallel output bus of the deserializer.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);

  logic             ser_in;
  logic             ser_valid;
  logic             ser_sof;
  logic             ser_ready;
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             par_ready;
  logic             sync_err;
  logic [CNT_W-1:0] word_cnt;

  // Environment side: drives the serial stream and the parallel ready.
  modport master (
    output ser_in, ser_valid, ser_sof, par_ready,
    input  ser_ready, par_data, par_valid, sync_err, word_cnt
  );

  // Deserializer side.
  modport slave (
    input  ser_in, ser_valid, ser_sof, par_ready,
    output ser_ready, par_data, par_valid, sync_err, word_cnt
  );

endinterface

// File: rtl/sipo_deserializer_out_reg.sv
// Parallel output holding register: load/consume handshake and delivered-word count.
module deser_out_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             consume,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  // A load wins over a consume in the same cycle, so valid stays high with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      data  <= word;
      valid <= 1'b1;
      cnt   <= cnt + CNT_W'(1);
    end else if (valid && consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with sof framing and valid/ready output.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  sipo_deserializer_if.slave bus
);

  localparam int unsigned      POS_W    = pos_width(WIDTH);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);

  state_e           state;
  logic [POS_W-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic             ready;
  logic             sync_err;

  logic             accept;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] idx;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             slot_free;
  logic             hold_release;
  logic             load;
  logic [WIDTH-1:0] load_word;

  assign bus.ser_ready = ready;
  assign bus.sync_err  = sync_err;

  // Bit placement and load decisions; a sof bit always restarts at position 0.
  always_comb begin
    accept       = bus.ser_valid & ready;
    pos          = bus.ser_sof ? '0 : cnt;
    idx          = MSB_FIRST ? (LAST_POS - pos) : pos;
    word         = bus.ser_sof ? '0 : sr;
    word[idx]    = bus.ser_in;
    last_bit     = accept && (state == SHIFT) && (pos == LAST_POS);
    slot_free    = !bus.par_valid || bus.par_ready;
    hold_release = (state == FULL) && bus.par_valid && bus.par_ready;
    load         = (last_bit && slot_free) || hold_release;
    load_word    = hold_release ? sr : word;
  end

  // Framing FSM, bit counter, shift register, registered ready and sync error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      ready    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      ready    <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept && bus.ser_sof) begin
            sr    <= word;
            cnt   <= POS_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            sync_err <= bus.ser_sof && (cnt != '0);
            if (last_bit) begin
              cnt <= '0;
              if (!slot_free) begin
                sr    <= word;
                state <= FULL;
                ready <= 1'b0;
              end
            end else begin
              sr  <= word;
              cnt <= pos + POS_W'(1);
            end
          end
        end
        FULL: begin
          if (hold_release) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  deser_out_reg #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .word   (load_word),
    .consume(bus.par_ready),
    .data   (bus.par_data),
    .valid  (bus.par_valid),
    .cnt    (bus.word_cnt)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus.
module tb_sipo_deserializer;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic ser_in    = 1'b0;
  logic ser_valid = 1'b0;
  logic ser_sof   = 1'b0;
  logic par_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  int         exp_words = 0;
  int         exp_sync  = 0;
  int         m_cnt     = 0;
  bit         m_active  = 1'b0;
  logic [7:0] m_w       = '0;
  logic [7:0] l_w       = '0;
  int         sync_hi_m = 0;
  int         sync_hi_l = 0;
  logic [7:0] w;

  initial forever #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(W), .CNT_W(CW)) bus_m ();
  sipo_deserializer_if #(.WIDTH(W), .CNT_W(CW)) bus_l ();

  assign bus_m.ser_in    = ser_in;
  assign bus_m.ser_valid = ser_valid;
  assign bus_m.ser_sof   = ser_sof;
  assign bus_m.par_ready = par_ready;
  assign bus_l.ser_in    = ser_in;
  assign bus_l.ser_valid = ser_valid;
  assign bus_l.ser_sof   = ser_sof;
  assign bus_l.par_ready = par_ready;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(CW)) dut_m (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(CW)) dut_l (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every word handed off is compared against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_m.par_valid && par_ready) begin
        if (q_m.size() == 0) check("m_unexpected_word", 32'(bus_m.par_data), 32'hFFFF_FFFF);
        else                 check("m_word", 32'(bus_m.par_data), 32'(q_m.pop_front()));
      end
      if (bus_l.par_valid && par_ready) begin
        if (q_l.size() == 0) check("l_unexpected_word", 32'(bus_l.par_data), 32'hFFFF_FFFF);
        else                 check("l_word", 32'(bus_l.par_data), 32'(q_l.pop_front()));
      end
      if (bus_m.sync_err) sync_hi_m++;
      if (bus_l.sync_err) sync_hi_l++;
    end
  end

  // Reference framing model, updated for every accepted bit.
  task automatic model_accept(input logic b, input logic sof);
    if (sof) begin
      if (m_active && m_cnt != 0) exp_sync++;
      m_active = 1'b1;
      m_cnt    = 0;
    end
    if (m_active) begin
      m_w = {m_w[6:0], b};
      l_w = {b, l_w[7:1]};
      m_cnt++;
      if (m_cnt == 8) begin
        q_m.push_back(m_w);
        q_l.push_back(l_w);
        exp_words++;
        m_cnt = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the bit was accepted.
  task automatic send_bit(input logic b, input logic sof);
    int waited;
    waited    = 0;
    ser_in    = b;
    ser_sof   = sof;
    ser_valid = 1'b1;
    @(negedge clk);
    while (!bus_m.ser_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_m.ser_ready) begin
      check("ready_timeout", 32'(bus_m.ser_ready), 32'd1);
      ser_valid = 1'b0;
      ser_sof   = 1'b0;
      cyc();
      return;
    end
    cyc();
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
    model_accept(b, sof);
  endtask

  task automatic send_word(input logic [7:0] wd, input bit sof, input bit bubbles);
    for (int i = 7; i >= 0; i--) begin
      if (bubbles && i != 7) cyc();
      send_bit(wd[i], sof && (i == 7));
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
    par_ready = 1'b0;
    q_m.delete();
    q_l.delete();
    m_active  = 1'b0;
    m_cnt     = 0;
    exp_words = 0;
    @(negedge clk);
    check("rst_ser_ready", 32'(bus_m.ser_ready), 32'd0);
    check("rst_par_valid", 32'(bus_m.par_valid | bus_l.par_valid), 32'd0);
    check("rst_par_data", 32'(bus_m.par_data | bus_l.par_data), 32'd0);
    check("rst_word_cnt", 32'(bus_m.word_cnt), 32'd0);
    check("rst_sync_err", 32'(bus_m.sync_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("rel_ser_ready", 32'(bus_m.ser_ready), 32'd1);
  endtask

  task automatic drain();
    par_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus_m.par_valid && !bus_l.par_valid) break;
    end
    check("drain_valid", 32'(bus_m.par_valid | bus_l.par_valid), 32'd0);
    check("drain_queue", 32'(q_m.size() + q_l.size()), 32'd0);
    check("drain_word_cnt", 32'(bus_m.word_cnt), 32'(exp_words));
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Reset in the middle of a word discards it; bits after release are dropped.
    par_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    check("post_reset_no_word", 32'(bus_m.par_valid | bus_l.par_valid), 32'd0);
    cyc();

    // Idle noise without sof, then a word with a bubble between bits.
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    check("idle_no_word", 32'(bus_m.par_valid | bus_l.par_valid), 32'd0);
    cyc();
    send_word(8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    check("bubble_valid", 32'(bus_m.par_valid), 32'd1);
    check("bubble_data", 32'(bus_m.par_data), 32'h5A);
    cyc();
    drain();

    // Basic word with latency check around the last bit.
    do_reset();
    par_ready = 1'b1;
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
    @(negedge clk);
    check("basic_pre_valid", 32'(bus_m.par_valid), 32'd0);
    cyc();
    send_bit(w[0], 1'b0);
    @(negedge clk);
    check("basic_valid", 32'(bus_m.par_valid), 32'd1);
    check("basic_data", 32'(bus_m.par_data), 32'hA5);
    check("basic_word_cnt", 32'(bus_m.word_cnt), 32'd1);
    cyc();
    drain();

    // Bit order for both instances.
    send_word(8'h12, 1'b1, 1'b0);
    @(negedge clk);
    check("order_msb", 32'(bus_m.par_data), 32'h12);
    check("order_lsb", 32'(bus_l.par_data), 32'h48);
    cyc();
    drain();

    // Back-pressure: second word is held until a one-cycle par_ready.
    par_ready = 1'b0;
    send_word(8'h12, 1'b1, 1'b0);
    send_word(8'h34, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready_low", 32'(bus_m.ser_ready), 32'd0);
    check("bp_hold_data", 32'(bus_m.par_data), 32'h12);
    check("bp_hold_valid", 32'(bus_m.par_valid), 32'd1);
    cyc();
    par_ready = 1'b1;
    cyc();
    par_ready = 1'b0;
    @(negedge clk);
    check("bp_next_data", 32'(bus_m.par_data), 32'h34);
    check("bp_next_valid", 32'(bus_m.par_valid), 32'd1);
    check("bp_ready_back", 32'(bus_m.ser_ready), 32'd1);
    check("bp_word_cnt", 32'(bus_m.word_cnt), 32'(exp_words));
    cyc();
    drain();

    // Word completing in the same cycle the previous one is consumed.
    par_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0);
    w = 8'h96;
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
    par_ready = 1'b1;
    send_bit(w[0], 1'b0);
    par_ready = 1'b0;
    @(negedge clk);
    check("simul_valid", 32'(bus_m.par_valid), 32'd1);
    check("simul_data", 32'(bus_m.par_data), 32'h96);
    check("simul_lsb_data", 32'(bus_l.par_data), 32'h69);
    check("simul_ready", 32'(bus_m.ser_ready), 32'd1);
    cyc();
    drain();

    // Resync: partial word abandoned by a new sof.
    par_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    w = 8'hC3;
    send_bit(w[7], 1'b1);
    @(negedge clk);
    check("resync_err_m", 32'(bus_m.sync_err), 32'd1);
    check("resync_err_l", 32'(bus_l.sync_err), 32'd1);
    cyc();
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    @(negedge clk);
    check("resync_err_gone", 32'(bus_m.sync_err), 32'd0);
    check("resync_data", 32'(bus_m.par_data), 32'hC3);
    cyc();
    drain();
    check("sync_pulses_m", 32'(sync_hi_m), 32'(exp_sync));
    check("sync_pulses_l", 32'(sync_hi_l), 32'(exp_sync));
    check("sync_pulse_count", 32'(sync_hi_m), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
